// File: rtl/core_pkg.sv
// Shared types for the execute-stage multi-cycle result buffer.
// The entry layout and pointer width are fixed here for the whole core.
package core_pkg;

  localparam int unsigned CORE_PAYLOAD_W = 64;
  localparam int unsigned CORE_RES_W     = 32;
  localparam int unsigned CORE_DEPTH     = 2;
  localparam int unsigned PTR_W          = $clog2(CORE_DEPTH);

  // pending is kept beside the storage because it must be reset, the data is not
  typedef struct packed {
    logic [CORE_PAYLOAD_W-1:0] payload;
    logic [CORE_RES_W-1:0]     result;
    logic                      from_mc;
  } mc_entry_t;

endpackage

// File: rtl/exe_mc_buf_mem.sv
// Entry storage: one full-entry write port, one result-only update port for
// multi-cycle completions, one asynchronous read port for the head.
module exe_mc_buf_mem
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = CORE_DEPTH
) (
  input  logic                  Clk,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_idx,
  input  mc_entry_t             wr_entry,
  input  logic                  upd_en,
  input  logic [PTR_W-1:0]      upd_idx,
  input  logic [CORE_RES_W-1:0] upd_result,
  input  logic [PTR_W-1:0]      rd_idx,
  output mc_entry_t             rd_entry
);

  mc_entry_t mem_q [DEPTH];

  // wr_idx and upd_idx never collide: the update target is occupied, the write target is free
  always_ff @(posedge Clk) begin
    if (wr_en)  mem_q[wr_idx]        <= wr_entry;
    if (upd_en) mem_q[upd_idx].result <= upd_result;
  end

  assign rd_entry = mem_q[rd_idx];

endmodule

// File: rtl/exe_mc_buf.sv
// In-order execute result buffer: single-cycle results and at most one
// outstanding multi-cycle op, retired to the next stage in program order.
module exe_mc_buf
  import core_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = CORE_PAYLOAD_W,
  parameter int unsigned RES_W     = CORE_RES_W,
  parameter int unsigned DEPTH     = CORE_DEPTH
) (
  input  logic                 Clk,
  input  logic                 Clr_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [RES_W-1:0]     in_result,
  output logic                 mc_req,
  input  logic                 mc_done,
  input  logic [RES_W-1:0]     mc_result,
  output logic                 mc_kill,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [RES_W-1:0]     out_result,
  output logic                 out_from_mc,
  input  logic                 flush,
  output logic                 busy,
  output logic                 mc_spurious
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both 1;
  // in_ready never depends on out_ready, and flush cancels every transfer in its cycle.

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr, mc_idx;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] pending;
  logic             mc_inflight;
  logic             push, pop, mc_complete;
  mc_entry_t        wr_entry, rd_entry;

  assign in_ready    = (count < FULL_CNT) && !(in_mc && mc_inflight);
  assign push        = in_valid && in_ready && !flush;
  assign out_valid   = (count != '0) && !pending[rd_ptr];
  assign pop         = out_valid && out_ready && !flush;
  assign mc_complete = mc_done && mc_inflight && !flush;

  assign mc_req      = push && in_mc;
  assign mc_kill     = flush && mc_inflight;
  assign mc_spurious = mc_done && !mc_inflight;
  assign busy        = mc_inflight;

  assign wr_entry.payload = in_payload;
  assign wr_entry.result  = in_mc ? '0 : in_result;
  assign wr_entry.from_mc = in_mc;

  assign out_payload = rd_entry.payload;
  assign out_result  = rd_entry.result;
  assign out_from_mc = rd_entry.from_mc;

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pending     <= '0;
      mc_inflight <= 1'b0;
      mc_idx      <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pending     <= '0;
      mc_inflight <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // completion is applied before a launch so the old op retires first
      if (mc_complete) begin
        pending[mc_idx] <= 1'b0;
        mc_inflight     <= 1'b0;
      end
      if (push) begin
        pending[wr_ptr] <= in_mc;
        if (in_mc) begin
          mc_inflight <= 1'b1;
          mc_idx      <= wr_ptr;
        end
      end
    end
  end

  exe_mc_buf_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .Clk       (Clk),
    .wr_en     (push),
    .wr_idx    (wr_ptr),
    .wr_entry  (wr_entry),
    .upd_en    (mc_complete),
    .upd_idx   (mc_idx),
    .upd_result(mc_result),
    .rd_idx    (rd_ptr),
    .rd_entry  (rd_entry)
  );

endmodule

// File: tb/tb_exe_mc_buf.sv
// Bench for exe_mc_buf: directed scenarios plus a random mixed stream,
// with retired results compared against an expected queue.
module tb_exe_mc_buf;

  localparam int PW = 64;
  localparam int RW = 32;
  localparam int EW = PW + RW + 1;

  logic          Clk = 1'b0;
  logic          Clr_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_mc = 1'b0;
  logic [PW-1:0] in_payload = '0;
  logic [RW-1:0] in_result = '0;
  logic          mc_req;
  logic          mc_done = 1'b0;
  logic [RW-1:0] mc_result = '0;
  logic          mc_kill;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_payload;
  logic [RW-1:0] out_result;
  logic          out_from_mc;
  logic          flush = 1'b0;
  logic          busy;
  logic          mc_spurious;

  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  // ---------------- clock / reset
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  exe_mc_buf #(
    .PAYLOAD_W(PW),
    .RES_W    (RW),
    .DEPTH    (2)
  ) dut (
    .Clk        (Clk),
    .Clr_n      (Clr_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mc      (in_mc),
    .in_payload (in_payload),
    .in_result  (in_result),
    .mc_req     (mc_req),
    .mc_done    (mc_done),
    .mc_result  (mc_result),
    .mc_kill    (mc_kill),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload(out_payload),
    .out_result (out_result),
    .out_from_mc(out_from_mc),
    .flush      (flush),
    .busy       (busy),
    .mc_spurious(mc_spurious)
  );

  // ---------------- checking
  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard: every retired entry is matched against exp_q
  always @(negedge Clk) begin
    if (Clr_n && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("out_extra", 128'(out_valid), 128'd0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check_eq("out_data", 128'({out_from_mc, out_payload, out_result}), 128'(e));
      end
    end
  end

  // ---------------- driver tasks
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic mc, input logic [PW-1:0] p, input logic [RW-1:0] r);
    in_valid   = v;
    in_mc      = mc;
    in_payload = p;
    in_result  = r;
  endtask

  task automatic expect_out(input logic mc, input logic [PW-1:0] p, input logic [RW-1:0] r);
    exp_q.push_back({mc, p, r});
  endtask

  // ---------------- stimulus
  logic [RW-1:0] ss_vals [3];
  int            mc_cnt;
  logic          busy_m;
  logic [RW-1:0] mc_res_m;
  logic          acc;
  int            cyc;

  initial begin
    ss_vals[0] = 32'h11; ss_vals[1] = 32'h22; ss_vals[2] = 32'h33;

    // reset state
    #2;
    check_eq("rst_out_valid", 128'(out_valid), 128'd0);
    check_eq("rst_in_ready", 128'(in_ready), 128'd1);
    check_eq("rst_mc_req", 128'(mc_req), 128'd0);
    check_eq("rst_mc_kill", 128'(mc_kill), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_mc_spurious", 128'(mc_spurious), 128'd0);
    repeat (2) @(posedge Clk);
    #1 Clr_n = 1'b1;
    step();

    // single-cycle stream, one-cycle latency, in_ready stays high
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_in(1'b1, 1'b0, 64'(i + 100), ss_vals[i]);
      expect_out(1'b0, 64'(i + 100), ss_vals[i]);
      @(negedge Clk);
      check_eq("ss_in_ready", 128'(in_ready), 128'd1);
      if (i > 0) check_eq("ss_latency", 128'(out_valid), 128'd1);
      step();
    end
    drive_in(1'b0, 1'b0, '0, '0);
    @(negedge Clk);
    check_eq("ss_last_valid", 128'(out_valid), 128'd1);
    check_eq("ss_last_result", 128'(out_result), 128'h33);
    step();
    @(negedge Clk);
    check_eq("ss_empty", 128'(out_valid), 128'd0);
    step();

    // order hold: mc op A then single-cycle B, done 5 cycles after A
    drive_in(1'b1, 1'b1, 64'hA0A0, '0);
    expect_out(1'b1, 64'hA0A0, 32'hAAAA);
    @(negedge Clk);
    check_eq("oh_mc_req", 128'(mc_req), 128'd1);
    step();
    drive_in(1'b1, 1'b0, 64'hB0B0, 32'hBB);
    expect_out(1'b0, 64'hB0B0, 32'hBB);
    @(negedge Clk);
    check_eq("oh_b_ready", 128'(in_ready), 128'd1);
    check_eq("oh_mc_req_b", 128'(mc_req), 128'd0);
    step();
    drive_in(1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check_eq("oh_hold", 128'(out_valid), 128'd0);
      check_eq("oh_busy", 128'(busy), 128'd1);
      step();
    end
    mc_done = 1'b1; mc_result = 32'hAAAA;
    @(negedge Clk);
    check_eq("oh_hold_done", 128'(out_valid), 128'd0);
    check_eq("oh_not_spur", 128'(mc_spurious), 128'd0);
    step();
    mc_done = 1'b0; mc_result = '0;
    @(negedge Clk);
    check_eq("oh_a_valid", 128'(out_valid), 128'd1);
    check_eq("oh_a_from_mc", 128'(out_from_mc), 128'd1);
    check_eq("oh_idle", 128'(busy), 128'd0);
    step();
    @(negedge Clk);
    check_eq("oh_b_result", 128'(out_result), 128'hBB);
    step();

    // backpressure / full
    out_ready = 1'b0;
    drive_in(1'b1, 1'b0, 64'h4444, 32'h44);
    expect_out(1'b0, 64'h4444, 32'h44);
    step();
    drive_in(1'b1, 1'b0, 64'h5555, 32'h55);
    expect_out(1'b0, 64'h5555, 32'h55);
    @(negedge Clk);
    check_eq("bp_second_ready", 128'(in_ready), 128'd1);
    step();
    drive_in(1'b0, 1'b0, '0, '0);
    @(negedge Clk);
    check_eq("bp_full", 128'(in_ready), 128'd0);
    check_eq("bp_valid", 128'(out_valid), 128'd1);
    step();
    out_ready = 1'b1;
    @(negedge Clk);
    step();
    out_ready = 1'b0;
    @(negedge Clk);
    check_eq("bp_ready_after_pop", 128'(in_ready), 128'd1);
    check_eq("bp_head_result", 128'(out_result), 128'h55);
    step();
    out_ready = 1'b1;
    @(negedge Clk);
    step();
    @(negedge Clk);
    check_eq("bp_drained", 128'(out_valid), 128'd0);
    step();

    // flush mid-op, then a late mc_done is spurious
    drive_in(1'b1, 1'b1, 64'hF1F1, '0);
    step();
    drive_in(1'b0, 1'b0, '0, '0);
    step();
    flush = 1'b1;
    drive_in(1'b1, 1'b0, 64'h9999, 32'h99);
    @(negedge Clk);
    check_eq("fl_mc_kill", 128'(mc_kill), 128'd1);
    check_eq("fl_mc_req", 128'(mc_req), 128'd0);
    step();
    flush = 1'b0;
    drive_in(1'b0, 1'b0, '0, '0);
    mc_done = 1'b1; mc_result = 32'hDEAD;
    @(negedge Clk);
    check_eq("fl_out_valid", 128'(out_valid), 128'd0);
    check_eq("fl_busy", 128'(busy), 128'd0);
    check_eq("fl_spurious", 128'(mc_spurious), 128'd1);
    check_eq("fl_kill_gone", 128'(mc_kill), 128'd0);
    step();
    mc_done = 1'b0; mc_result = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge Clk);
      check_eq("fl_no_output", 128'(out_valid), 128'd0);
      check_eq("fl_spur_pulse", 128'(mc_spurious), 128'd0);
      step();
    end

    // second mc op blocked while busy, accepted the cycle after mc_done
    drive_in(1'b1, 1'b1, 64'hA2A2, '0);
    expect_out(1'b1, 64'hA2A2, 32'h1234);
    @(negedge Clk);
    check_eq("b2_first_req", 128'(mc_req), 128'd1);
    step();
    drive_in(1'b1, 1'b1, 64'hC0C0, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check_eq("b2_blocked", 128'(in_ready), 128'd0);
      check_eq("b2_no_req", 128'(mc_req), 128'd0);
      step();
    end
    mc_done = 1'b1; mc_result = 32'h1234;
    @(negedge Clk);
    check_eq("b2_blocked_done", 128'(in_ready), 128'd0);
    step();
    mc_done = 1'b0; mc_result = '0;
    @(negedge Clk);
    check_eq("b2_ready", 128'(in_ready), 128'd1);
    check_eq("b2_req", 128'(mc_req), 128'd1);
    expect_out(1'b1, 64'hC0C0, 32'h5678);
    step();
    drive_in(1'b0, 1'b0, '0, '0);
    step();
    mc_done = 1'b1; mc_result = 32'h5678;
    step();
    mc_done = 1'b0; mc_result = '0;
    step();
    step();
    @(negedge Clk);
    check_eq("b2_done_idle", 128'(busy), 128'd0);
    check_eq("b2_empty", 128'(out_valid), 128'd0);
    step();

    // asynchronous reset between edges with two entries held and an op in flight
    out_ready = 1'b0;
    drive_in(1'b1, 1'b0, 64'h6666, 32'h66);
    step();
    drive_in(1'b1, 1'b1, 64'h7777, '0);
    step();
    drive_in(1'b0, 1'b0, '0, '0);
    @(negedge Clk);
    check_eq("ar_pre_valid", 128'(out_valid), 128'd1);
    check_eq("ar_pre_busy", 128'(busy), 128'd1);
    #1 Clr_n = 1'b0;
    #1;
    check_eq("ar_out_valid", 128'(out_valid), 128'd0);
    check_eq("ar_in_ready", 128'(in_ready), 128'd1);
    check_eq("ar_busy", 128'(busy), 128'd0);
    check_eq("ar_no_kill", 128'(mc_kill), 128'd0);
    @(posedge Clk);
    #1 Clr_n = 1'b1;
    step();

    // random mixed stream with a multi-cycle unit responding after 1..5 cycles
    mc_cnt = 0;
    busy_m = 1'b0;
    mc_res_m = '0;
    cyc = 0;
    while (cyc < 400 && !(cyc >= 250 && exp_q.size() == 0)) begin
      out_ready  = ($urandom_range(0, 3) != 0);
      mc_done    = (mc_cnt == 1);
      mc_result  = mc_done ? mc_res_m : $urandom;
      in_valid   = (cyc < 250) && ($urandom_range(0, 2) != 0);
      in_mc      = ($urandom_range(0, 3) == 0);
      in_payload = {$urandom, $urandom};
      in_result  = $urandom;
      @(negedge Clk);
      acc = in_valid && in_ready;
      check_eq("rnd_busy", 128'(busy), 128'(busy_m));
      check_eq("rnd_mc_req", 128'(mc_req), 128'(acc && in_mc));
      if (busy_m && in_mc) check_eq("rnd_mc_block", 128'(in_ready), 128'd0);
      if (acc) begin
        if (in_mc) begin
          mc_res_m = $urandom;
          expect_out(1'b1, in_payload, mc_res_m);
        end else begin
          expect_out(1'b0, in_payload, in_result);
        end
      end
      step();
      if (mc_cnt == 1) begin
        mc_cnt = 0;
        busy_m = 1'b0;
      end else if (mc_cnt > 1) begin
        mc_cnt--;
      end
      if (acc && in_mc) begin
        mc_cnt = $urandom_range(1, 5);
        busy_m = 1'b1;
      end
      cyc++;
    end
    drive_in(1'b0, 1'b0, '0, '0);
    mc_done = 1'b0;
    check_eq("rnd_drained", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
